// File: rtl/pipe_sqrt_n.sv
// Fully pipelined integer square root, one root bit per stage, MSB first.
// Valid/ready flow control with a global stall; optional round-to-nearest.
module pipe_sqrt_n #(
  parameter int W     = 16,
  parameter int ROUND = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W/2-1:0] B,
  output logic [W/2:0]   R
);

  localparam int N = W / 2;

  if ((W < 4) || ((W % 2) != 0)) begin : g_bad_width
    $error("pipe_sqrt_n: W must be even and >= 4");
  end

  logic           en_s;
  logic [N:0]     vld_r;
  logic [W-1:0]   rad_r  [0:N-1];
  logic [N-1:0]   root_r [0:N-1];
  logic [N:0]     rem_r  [0:N-1];
  logic [W-1:0]   rad_s  [1:N];
  logic [N-1:0]   root_s [1:N];
  logic [N:0]     rem_s  [1:N];
  logic [N-1:0]   b_s;

  assign en_s      = out_ready | ~vld_r[N];
  assign in_ready  = en_s & ~rst;
  assign out_valid = vld_r[N];

  // Stage i brings down the next two radicand bits and decides root bit N-i.
  for (genvar i = 1; i <= N; i++) begin : g_stage
    logic [N+2:0] trial_s;
    logic [N+2:0] test_s;
    logic [N+2:0] diff_s;

    // One digit-by-digit step: subtract (4*root+1) when it fits.
    always_comb begin
      trial_s = {rem_r[i-1], rad_r[i-1][W-1:W-2]};
      test_s  = {1'b0, root_r[i-1], 2'b01};
      diff_s  = trial_s - test_s;
      rad_s[i] = {rad_r[i-1][W-3:0], 2'b00};
      if (trial_s >= test_s) begin
        rem_s[i]  = diff_s[N:0];
        root_s[i] = {root_r[i-1][N-2:0], 1'b1};
      end else begin
        rem_s[i]  = trial_s[N:0];
        root_s[i] = {root_r[i-1][N-2:0], 1'b0};
      end
    end
  end

  // Round up when the floor remainder exceeds the floor root, saturating at all-ones.
  always_comb begin
    if ((ROUND != 0) && (rem_s[N] > {1'b0, root_s[N]}) && (root_s[N] != {N{1'b1}})) begin
      b_s = root_s[N] + {{(N-1){1'b0}}, 1'b1};
    end else begin
      b_s = root_s[N];
    end
  end

  // Valid chain and output registers; the only reset state in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {(N+1){1'b0}};
      B     <= {N{1'b0}};
      R     <= {(N+1){1'b0}};
    end else if (en_s) begin
      vld_r <= {vld_r[N-1:0], in_valid};
      B     <= b_s;
      R     <= rem_s[N];
    end
  end

  // Datapath stage registers shift together with the valid chain.
  always_ff @(posedge clk) begin
    if (en_s) begin
      rad_r[0]  <= A;
      root_r[0] <= {N{1'b0}};
      rem_r[0]  <= {(N+1){1'b0}};
      for (int k = 1; k < N; k++) begin
        rad_r[k]  <= rad_s[k];
        root_r[k] <= root_s[k];
        rem_r[k]  <= rem_s[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_sqrt_n.sv
// Scoreboard bench for pipe_sqrt_n: three configurations run side by side,
// each with its own driver, monitor and expected-result queue.
module tb_pipe_sqrt_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int W   = (g == 2) ? 16 : 8;
    localparam int RND = (g == 1) ? 1 : 0;
    localparam int N   = W / 2;

    typedef struct {
      logic [N-1:0] b;
      logic [N:0]   r;
      logic [W-1:0] a;
      int           acc;
      int           stl;
    } exp_t;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] B;
    logic [N:0]   R;
    logic         rmode = 1'b0;
    logic         done = 1'b0;
    logic         tmo = 1'b0;
    exp_t         q[$];
    int           cyc = 0;

    pipe_sqrt_n #(.W(W), .ROUND(RND)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A),
      .out_valid(out_valid), .out_ready(out_ready), .B(B), .R(R)
    );

    // Reference: floor root by counting up, rounded root via real sqrt.
    function automatic exp_t model(input logic [W-1:0] a);
      exp_t   e;
      longint v;
      longint f;
      longint n;
      v = longint'(a);
      f = 0;
      while ((f + 1) * (f + 1) <= v) f++;
      n = f;
      if (RND != 0) begin
        n = longint'($rtoi($sqrt(real'(v)) + 0.5));
        if (n > (longint'(1) << N) - 1) n = (longint'(1) << N) - 1;
      end
      e.b   = n[N-1:0];
      e.r   = (N+1)'(v - f * f);
      e.a   = a;
      e.acc = 0;
      e.stl = 0;
      return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
      forever begin
        @(posedge clk);
        #1;
        out_ready = rmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end

    // Monitor: flow-control rules, hold, latency and result order.
    initial begin
      exp_t         e;
      int           stl = 0;
      logic         held = 1'b0;
      logic         head_seen = 1'b0;
      logic         rst_prev = 1'b0;
      logic [N-1:0] hb = '0;
      logic [N:0]   hr = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg%0d in_ready_in_reset got=%b want=0", g, in_ready);
          end
          q.delete();
          held = 1'b0;
          head_seen = 1'b0;
          rst_prev = 1'b1;
        end else begin
          if (rst_prev) begin
            checks++;
            if (out_valid !== 1'b0 || B !== '0 || R !== '0) begin
              errors++;
              $display("FAIL cfg%0d after_reset got valid=%b B=%0d R=%0d want 0/0/0", g, out_valid, B, R);
            end
          end
          rst_prev = 1'b0;
          checks++;
          if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL cfg%0d in_ready got=%b want=%b", g, in_ready, !(out_valid && !out_ready));
          end
          if (held) begin
            checks++;
            if (out_valid !== 1'b1 || B !== hb || R !== hr) begin
              errors++;
              $display("FAIL cfg%0d hold got valid=%b B=%0d R=%0d want 1/%0d/%0d", g, out_valid, B, R, hb, hr);
            end
          end
          if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL cfg%0d unexpected_result B=%0d R=%0d want none", g, B, R);
            end else begin
              if (!head_seen) begin
                checks++;
                if (cyc != q[0].acc + N + (stl - q[0].stl)) begin
                  errors++;
                  $display("FAIL cfg%0d latency A=%0d got_edge=%0d want_edge=%0d", g, q[0].a, cyc,
                           q[0].acc + N + (stl - q[0].stl));
                end
                head_seen = 1'b1;
              end
              if (out_ready) begin
                checks++;
                if (B !== q[0].b || R !== q[0].r) begin
                  errors++;
                  $display("FAIL cfg%0d result A=%0d got B=%0d R=%0d want B=%0d R=%0d", g, q[0].a, B, R,
                           q[0].b, q[0].r);
                end
                void'(q.pop_front());
                head_seen = 1'b0;
              end
            end
          end
          held = out_valid && !out_ready;
          hb = B;
          hr = R;
          if (out_valid && !out_ready) stl++;
          if (in_valid && in_ready) begin
            e = model(A);
            e.acc = cyc + 1;
            e.stl = stl;
            q.push_back(e);
          end
        end
      end
    end

    task automatic send(input logic [W-1:0] a);
      int n;
      n = 0;
      in_valid = 1'b1;
      A = a;
      do begin
        @(negedge clk);
        n++;
      end while (!in_ready && n < 500);
      if (!in_ready) tmo = 1'b1;
      @(posedge clk);
      #1;
    endtask

    task automatic idle();
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (q.size() != 0 && n < 3000) begin
        @(posedge clk);
        n++;
      end
      if (q.size() != 0) tmo = 1'b1;
      rmode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    endtask

    task automatic random_burst(input int cnt);
      rmode = 1'b1;
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(posedge clk);
          #1;
        end
        send(W'($urandom));
      end
      drain();
    endtask

    task automatic reset_midway();
      send(W'($urandom));
      send(W'($urandom));
      send(W'($urandom));
      idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(W'(144));
      idle();
      drain();
    endtask

    // Driver: directed cases first, then exhaustive / random traffic.
    initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      if (g == 0) begin
        send(W'(200));
        drain();
        for (int a = 0; a < 256; a++) send(W'(a));
        drain();
        random_burst(20);
        reset_midway();
      end else if (g == 1) begin
        send(W'(210));
        send(W'(211));
        send(W'(255));
        send(W'(0));
        drain();
        for (int a = 0; a < 256; a++) send(W'(a));
        drain();
        random_burst(20);
      end else begin
        send(W'(65535));
        send(W'(65025));
        send(W'(1));
        drain();
        random_burst(20);
        reset_midway();
        random_burst(10);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(gen[0].done && gen[1].done && gen[2].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!(gen[0].done && gen[1].done && gen[2].done)) begin
      errors++;
      $display("FAIL run_timeout done=%b%b%b want 111", gen[2].done, gen[1].done, gen[0].done);
    end
    checks++;
    if (gen[0].tmo || gen[1].tmo || gen[2].tmo) begin
      errors++;
      $display("FAIL handshake_timeout tmo=%b%b%b want 000", gen[2].tmo, gen[1].tmo, gen[0].tmo);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
